// File: rtl/aes_pkg.sv
// ----------------------------------------------------------------------------
// aes_pkg
// Shared AES types, the GF(2^8) reduction constant, FSM encoding for the
// iterative MixColumns stage, and byte/column helper functions.
//   xtime   : multiply a byte by {02} in GF(2^8) modulo x^8+x^4+x^3+x+1
//   gmul    : multiply a byte by a 4-bit constant (covers 01,02,03,09,0b,0d,0e)
//   col_get : extract column c of a row-major state, byte (0,c) most significant
//   col_put : return the state with column c replaced by a 32-bit word
// ----------------------------------------------------------------------------
package aes_pkg;

    typedef logic [127:0] aes_state_t;
    typedef logic [31:0]  aes_word_t;
    typedef logic [7:0]   aes_byte_t;

    // Low byte of the field polynomial 0x11b; bit 8 is implied by the shift-out.
    localparam aes_byte_t AES_POLY = 8'h1b;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } mc_state_e;

    function automatic aes_byte_t xtime(input aes_byte_t b);
        return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
    endfunction

    // Shift-and-add over the four constant bits, unrolled.
    function automatic aes_byte_t gmul(input aes_byte_t b, input logic [3:0] k);
        aes_byte_t p0;
        aes_byte_t p1;
        aes_byte_t p2;
        aes_byte_t p3;
        p0 = b;
        p1 = xtime(p0);
        p2 = xtime(p1);
        p3 = xtime(p2);
        return (k[0] ? p0 : 8'h00) ^ (k[1] ? p1 : 8'h00) ^
               (k[2] ? p2 : 8'h00) ^ (k[3] ? p3 : 8'h00);
    endfunction

    // MSB index of byte (0,c); rows follow at 32-bit strides below it.
    function automatic logic [6:0] col_msb(input logic [1:0] c);
        return 7'd127 - {2'b00, c, 3'b000};
    endfunction

    function automatic aes_word_t col_get(input aes_state_t s, input logic [1:0] c);
        logic [6:0] b;
        b = col_msb(c);
        return {s[b -: 8], s[b - 7'd32 -: 8], s[b - 7'd64 -: 8], s[b - 7'd96 -: 8]};
    endfunction

    function automatic aes_state_t col_put(input aes_state_t s, input logic [1:0] c,
                                           input aes_word_t w);
        aes_state_t r;
        logic [6:0] b;
        r = s;
        b = col_msb(c);
        r[b -: 8]          = w[31:24];
        r[b - 7'd32 -: 8]  = w[23:16];
        r[b - 7'd64 -: 8]  = w[15:8];
        r[b - 7'd96 -: 8]  = w[7:0];
        return r;
    endfunction

endpackage

// File: rtl/mix_column_word.sv
// ----------------------------------------------------------------------------
// mix_column_word
// Combinational GF(2^8) transform of one AES column.
//   col_in   : column {a0,a1,a2,a3}, a0 in bits [31:24]
//   fwd_ninv : 1 = MixColumns matrix [02 03 01 01], 0 = InvMixColumns [0e 0b 0d 09]
//   col_out  : transformed column, same byte order
// Each output row uses the base coefficient row rotated right by the row index.
// ----------------------------------------------------------------------------
module mix_column_word
    import aes_pkg::*;
(
    input  logic [31:0] col_in,
    input  logic        fwd_ninv,
    output logic [31:0] col_out
);

    aes_byte_t  a0_s, a1_s, a2_s, a3_s;
    logic [3:0] m0_s, m1_s, m2_s, m3_s;

    assign a0_s = col_in[31:24];
    assign a1_s = col_in[23:16];
    assign a2_s = col_in[15:8];
    assign a3_s = col_in[7:0];

    // Select the base coefficient row for the requested direction.
    always_comb begin
        m0_s = 4'h2;
        m1_s = 4'h3;
        m2_s = 4'h1;
        m3_s = 4'h1;
        if (fwd_ninv) begin
            m0_s = 4'h2;
            m1_s = 4'h3;
            m2_s = 4'h1;
            m3_s = 4'h1;
        end else begin
            m0_s = 4'he;
            m1_s = 4'hb;
            m2_s = 4'hd;
            m3_s = 4'h9;
        end
    end

    assign col_out[31:24] = gmul(a0_s, m0_s) ^ gmul(a1_s, m1_s) ^ gmul(a2_s, m2_s) ^ gmul(a3_s, m3_s);
    assign col_out[23:16] = gmul(a0_s, m3_s) ^ gmul(a1_s, m0_s) ^ gmul(a2_s, m1_s) ^ gmul(a3_s, m2_s);
    assign col_out[15:8]  = gmul(a0_s, m2_s) ^ gmul(a1_s, m3_s) ^ gmul(a2_s, m0_s) ^ gmul(a3_s, m1_s);
    assign col_out[7:0]   = gmul(a0_s, m1_s) ^ gmul(a1_s, m2_s) ^ gmul(a2_s, m3_s) ^ gmul(a3_s, m0_s);

endmodule

// File: rtl/mix_columns_iter.sv
// ----------------------------------------------------------------------------
// mix_columns_iter
// Iterative AES MixColumns / InvMixColumns stage, COLS_PER_CYCLE columns per
// clock (1, 2 or 4), with a bypass for the final AES round.
//   clk_i, rst_i           : clock, asynchronous active-high reset
//   in_valid_i/in_ready_o  : input handshake; in_ready_o only in IDLE
//   fwd_ninv_i, bypass_i   : mode, captured only on the accept edge
//   in_state               : 128-bit row-major input state
//   out_valid_o/out_ready_i: output handshake; result held under backpressure
//   out_state              : working register, driven straight from flops
// ----------------------------------------------------------------------------
module mix_columns_iter
    import aes_pkg::*;
#(
    parameter int unsigned COLS_PER_CYCLE = 32'd1
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic         fwd_ninv_i,
    input  logic         bypass_i,
    input  logic [127:0] in_state,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [127:0] out_state
);

    // Counter stride and the column index that starts the final group.
    localparam logic [1:0] COL_STEP = 2'(COLS_PER_CYCLE);
    localparam logic [1:0] LAST_COL = 2'(32'd4 - COLS_PER_CYCLE);

    mc_state_e  state_r, state_s;
    logic [1:0] col_q;
    aes_state_t work_r;
    logic       fwd_r;
    logic       accept_s;
    logic       last_s;
    logic       in_ready_r, in_ready_s;
    logic       out_valid_r, out_valid_s;

    aes_word_t  col_in_s  [COLS_PER_CYCLE];
    aes_word_t  col_out_s [COLS_PER_CYCLE];
    logic [1:0] col_idx_s [COLS_PER_CYCLE];
    // stage_s[g] is the working state with the first g columns of this edge merged.
    aes_state_t stage_s   [COLS_PER_CYCLE + 32'd1];

    assign accept_s = in_valid_i && (state_r == ST_IDLE);
    assign last_s   = (col_q == LAST_COL);

    assign stage_s[0] = work_r;

    for (genvar g = 32'd0; g < COLS_PER_CYCLE; g++) begin : g_col
        assign col_idx_s[g] = col_q + 2'(g);
        assign col_in_s[g]  = col_get(work_r, col_idx_s[g]);

        mix_column_word u_word (
            .col_in   (col_in_s[g]),
            .fwd_ninv (fwd_r),
            .col_out  (col_out_s[g])
        );

        assign stage_s[g + 1] = col_put(stage_s[g], col_idx_s[g], col_out_s[g]);
    end

    // FSM state register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_s = bypass_i ? ST_DONE : ST_BUSY;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (last_s) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_BUSY;
                end
            end
            ST_DONE: begin
                if (out_ready_i) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DONE;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // FSM output decode from the next state, so the handshake flags are flops.
    always_comb begin
        in_ready_s  = 1'b0;
        out_valid_s = 1'b0;
        case (state_s)
            ST_IDLE: begin
                in_ready_s  = 1'b1;
                out_valid_s = 1'b0;
            end
            ST_BUSY: begin
                in_ready_s  = 1'b0;
                out_valid_s = 1'b0;
            end
            ST_DONE: begin
                in_ready_s  = 1'b0;
                out_valid_s = 1'b1;
            end
            default: begin
                in_ready_s  = 1'b0;
                out_valid_s = 1'b0;
            end
        endcase
    end

    // Handshake output registers; in_ready is up straight out of reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            in_ready_r  <= in_ready_s;
            out_valid_r <= out_valid_s;
        end
    end

    // Working register: load on accept, update columns in place while busy.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            work_r <= 128'h0;
            fwd_r  <= 1'b0;
            col_q  <= 2'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        work_r <= in_state;
                        fwd_r  <= fwd_ninv_i;
                        col_q  <= 2'd0;
                    end else begin
                        work_r <= work_r;
                    end
                end
                ST_BUSY: begin
                    work_r <= stage_s[COLS_PER_CYCLE];
                    col_q  <= col_q + COL_STEP;
                end
                default: begin
                    work_r <= work_r;
                end
            endcase
        end
    end

    assign in_ready_o  = in_ready_r;
    assign out_valid_o = out_valid_r;
    assign out_state   = work_r;

endmodule

// File: doc/mix_columns_iter.md
Name: mix_columns_iter

Overview:
- AES MixColumns / InvMixColumns round stage, placed directly downstream of the ShiftRows stage; consumes its 128-bit state.
- Iterative: processes COLS_PER_CYCLE columns per clock, sharing the GF(2^8) column datapath.
- Valid/ready handshake on both sides; final-round bypass for the AES last round, which has no MixColumns.

Parameters:
- COLS_PER_CYCLE, 1, columns transformed per clock; legal values 1, 2, 4. Processing latency is 4/COLS_PER_CYCLE cycles.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset; asynchronous, active-high
- in_valid_i  in  1  input state valid
- in_ready_o  out  1  block can accept a state
- fwd_ninv_i  in  1  1 = MixColumns (encrypt), 0 = InvMixColumns; sampled on accept
- bypass_i  in  1  1 = pass the state through unchanged (final round); sampled on accept
- in_state  in  128  input state, row-major
- out_valid_o  out  1  out_state valid
- out_ready_i  in  1  consumer accepts out_state
- out_state  out  128  result state, row-major

Behaviour:
- State layout: row r = bits [127-32r -: 32]; byte (r,c) = bits [127-32r-8c -: 8]. Column c = {(0,c),(1,c),(2,c),(3,c)}, with (0,c) as the most significant byte.
- Forward transform per column: matrix [02 03 01 01] rotated by row. Inverse: [0e 0b 0d 09] rotated by row. Multiplication is in GF(2^8) with polynomial 0x11b.
- FSM states are IDLE, BUSY and DONE. A 2-bit column counter col_q is used in BUSY.
- IDLE:
  - in_ready_o = 1, out_valid_o = 0.
  - Accept on in_valid_i && in_ready_o: register in_state, fwd_ninv_i and bypass_i; set col_q = 0.
  - If bypass_i = 1, go to DONE. Otherwise go to BUSY.
- BUSY:
  - Each edge replaces columns col_q .. col_q+COLS_PER_CYCLE-1 of the working register in place.
  - col_q += COLS_PER_CYCLE; the counter wraps modulo 4.
  - On the edge that processes column 3, go to DONE.
  - in_ready_o = 0 throughout.
- DONE:
  - out_valid_o = 1; out_state = working register.
  - Hold out_state stable while out_ready_i = 0 (backpressure). Hold for any duration.
  - On out_ready_i = 1, go to IDLE. No accept occurs in the same cycle, because in_ready_o is 0 in DONE.
- Latency, counted from the accept edge to out_valid_o high:
  - bypass: 1 cycle.
  - otherwise: 1 + 4/COLS_PER_CYCLE cycles, i.e. 5 / 3 / 2 for COLS_PER_CYCLE = 1 / 2 / 4.
- Mode inputs and in_state are ignored outside the accept cycle. Changing fwd_ninv_i mid-operation has no effect.
- Reset, at any time including mid-BUSY or DONE:
  - state = IDLE, col_q = 0, working register = 0.
  - out_state = 0, out_valid_o = 0, in_ready_o = 1 once reset is released.
  - The partial result is discarded.
- in_valid_i while busy: the state is not accepted. The upstream stage holds it until in_ready_o = 1.
- out_state is driven directly from the register, with no combinational path from inputs to outputs.

Decomposition:
- Package aes_pkg:
  - typedefs: aes_state_t (logic [127:0]), aes_word_t (logic [31:0]), aes_byte_t (logic [7:0]).
  - constants: AES_POLY = 8'h1b.
  - functions: xtime(), gmul() (byte by 4-bit constant), col_get(state, c), col_put(state, c, word).
- Sub-module mix_column_word: purely combinational. Ports are 32-bit column in, fwd_ninv, 32-bit column out. Instantiated COLS_PER_CYCLE times.

Test Plan:
- Forward, COLS_PER_CYCLE = 1, in_state = 128'hdbf2012d_130a0126_53220131_455c014c:
  - out_state = 128'h8e9f014d_4ddc017e_a15801bd_bc9d01f8.
  - out_valid_o rises 5 cycles after the accept.
- Inverse of 128'h8e9f014d_4ddc017e_a15801bd_bc9d01f8 -> 128'hdbf2012d_130a0126_53220131_455c014c. Repeat for COLS_PER_CYCLE = 2 and 4 with latencies 3 and 2.
- bypass_i = 1, in_state = 128'h00112233_44556677_8899aabb_ccddeeff -> identical out_state, out_valid_o 1 cycle after the accept.
- Backpressure:
  - Hold out_ready_i = 0 for 10 cycles: out_state is stable, in_ready_o = 0.
  - A second in_valid_i with different data is not accepted until the cycle after out_ready_i = 1.
- Reset mid-BUSY, asserted after 2 processing edges:
  - out_valid_o = 0, out_state = 0, in_ready_o = 1.
  - The next transaction (c6c6c6c6 column in every column, i.e. in_state = 128'hc6c6c6c6_c6c6c6c6_c6c6c6c6_c6c6c6c6) yields the same value.
- Back-to-back random states with out_ready_i held at 1, each compared against a software model (forward, then inverse returns the original); throughput is one result per latency+1 cycles.
